// File: rtl/seg_pkg.sv
// Shared constants and hex decode for the 4-digit seven-segment scanner.
// Segment codes are active-low, ordered gfedcba.
package seg_pkg;

    localparam int NDIGITS = 4;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Packed, so element n is the code for hex digit n.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        return SEG_HEX[nib];
    endfunction

endpackage

// File: rtl/scan_tick.sv
// Scan prescaler: free-running 0..DIV-1 counter, tick on the last count.
// Latency: tick is combinational from the counter; no backpressure.
// Backpressure: none, runs every clock.
module scan_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit hex display scanner with frame-aligned value commit.
// Latency: an/seg/dp registered, 1 cycle after idx/active.
// Backpressure: none; loads are always accepted, ready only reports a pending commit.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIV      = 4,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    output logic        ready,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    logic        tick;
    logic        frame_end;
    logic [1:0]  idx;
    logic [15:0] active;
    logic [15:0] shadow;
    logic [3:0]  active_dp;
    logic [3:0]  shadow_dp;
    logic        pending;

    scan_tick #(.DIV(DIV)) u_scan_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign frame_end = tick && (idx == 2'(NDIGITS - 1));
    assign ready     = ~pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (tick) begin
            idx <= idx + 1'b1;
        end
    end

    // The displayed value only changes on a frame boundary so a digit never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            active    <= '0;
            active_dp <= '0;
            shadow    <= '0;
            shadow_dp <= '0;
            pending   <= 1'b0;
        end else begin
            if (load) begin
                shadow    <= value;
                shadow_dp <= dp_in;
            end
            if (load && frame_end) begin
                active    <= value;
                active_dp <= dp_in;
                pending   <= 1'b0;
            end else if (frame_end && pending) begin
                active    <= shadow;
                active_dp <= shadow_dp;
                pending   <= 1'b0;
            end else if (load) begin
                pending   <= 1'b1;
            end
        end
    end

    logic [3:0]  nib;
    logic [15:0] upper;
    logic        blank;
    logic [3:0]  an_nxt;
    logic [6:0]  seg_nxt;
    logic        dp_nxt;

    always_comb begin
        nib     = active[{idx, 2'b00} +: 4];
        upper   = active >> {idx, 2'b00};
        blank   = BLANK_LZ && (idx != 2'd0) && (upper == 16'h0);
        an_nxt  = ~(4'b0001 << idx);
        seg_nxt = blank ? SEG_OFF : hex2seg(nib);
        dp_nxt  = ~active_dp[idx];
        if (!en) begin
            an_nxt  = 4'b1111;
            seg_nxt = SEG_OFF;
            dp_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl at DIV=4, BLANK_LZ=1: a cycle model
// predicts each registered output and queues it until the DUT presents it.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        ready;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .load  (load),
        .value (value),
        .dp_in (dp_in),
        .ready (ready),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s/%s got %0h exp %0h", phase, tag, got, exp);
        end
    endtask

    logic [6:0] segtab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int          m_pre  = 0;
    logic [1:0]  m_idx  = 2'd0;
    logic [15:0] m_act  = 16'h0;
    logic [15:0] m_shd  = 16'h0;
    logic [3:0]  m_dp   = 4'h0;
    logic [3:0]  m_sdp  = 4'h0;
    logic        m_pend = 1'b0;
    logic [11:0] sbq [$];

    function automatic logic [11:0] model_out();
        logic [3:0] n;
        logic [6:0] s;
        logic       blank;
        n     = m_act[m_idx*4 +: 4];
        blank = 1'b0;
        if (m_idx != 2'd0) begin
            blank = 1'b1;
            for (int i = int'(m_idx); i < 4; i++)
                if (m_act[i*4 +: 4] != 4'h0) blank = 1'b0;
        end
        s = blank ? 7'b1111111 : segtab[n];
        return {~(4'b0001 << m_idx), s, ~m_dp[m_idx]};
    endfunction

    task automatic step(input bit r, input bit e, input bit l,
                        input logic [15:0] v, input logic [3:0] d);
        logic [11:0] exp;
        bit          tk;
        bit          fe;
        @(negedge clk);
        rst = r; en = e; load = l; value = v; dp_in = d;
        if (r || !e) sbq.push_back(12'hfff);
        else         sbq.push_back(model_out());
        if (r) begin
            m_pre = 0; m_idx = 2'd0; m_act = '0; m_shd = '0;
            m_dp = '0; m_sdp = '0; m_pend = 1'b0;
        end else begin
            tk = (m_pre == 3);
            fe = tk && (m_idx == 2'd3);
            if (l) begin
                m_shd = v; m_sdp = d;
            end
            if (l && fe) begin
                m_act = v; m_dp = d; m_pend = 1'b0;
            end else if (fe && m_pend) begin
                m_act = m_shd; m_dp = m_sdp; m_pend = 1'b0;
            end else if (l) begin
                m_pend = 1'b1;
            end
            m_pre = tk ? 0 : m_pre + 1;
            if (tk) m_idx = m_idx + 2'd1;
        end
        @(posedge clk);
        #1;
        exp = sbq.pop_front();
        check("an",    32'(an),    32'(exp[11:8]));
        check("seg",   32'(seg),   32'(exp[7:1]));
        check("dp",    32'(dp),    32'(exp[0]));
        check("ready", 32'(ready), 32'(!m_pend));
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; load = 1'b0; value = '0; dp_in = '0;

        phase = "reset";
        repeat (3) step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
        check("rst_an", 32'(an), 32'hf);
        check("rst_seg", 32'(seg), 32'h7f);

        phase = "scan";
        idle(1);
        check("first_an", 32'(an), 32'b1110);
        check("first_seg", 32'(seg), 32'b1000000);
        idle(19);

        phase = "lzblank";
        idle(5);
        step(1'b0, 1'b1, 1'b1, 16'h00A5, 4'h0);
        check("pend_ready", 32'(ready), 32'h0);
        idle(40);

        phase = "lastwins";
        for (int k = 0; k < 20 && !(m_idx == 2'd0 && m_pre == 1); k++) idle(1);
        step(1'b0, 1'b1, 1'b1, 16'h1234, 4'h0);
        idle(2);
        step(1'b0, 1'b1, 1'b1, 16'h5678, 4'h0);
        idle(40);

        phase = "fe_load";
        for (int k = 0; k < 20 && !(m_pre == 3 && m_idx == 2'd3); k++) idle(1);
        step(1'b0, 1'b1, 1'b1, 16'hF00F, 4'b0100);
        check("fe_ready", 32'(ready), 32'h1);
        idle(40);

        phase = "enable";
        repeat (10) step(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
        idle(20);

        phase = "rst_load";
        for (int k = 0; k < 20 && !(m_pre == 0); k++) idle(1);
        step(1'b0, 1'b1, 1'b1, 16'h4321, 4'hA);
        step(1'b1, 1'b1, 1'b1, 16'hBEEF, 4'hF);
        check("rl_ready", 32'(ready), 32'h1);
        check("rl_an", 32'(an), 32'hf);
        idle(20);

        phase = "random";
        repeat (300)
            step(1'b0, $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
                 16'($urandom), 4'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 4, meaning clocks per digit slot (DIV >= 2).
REQ-002 SHALL have parameter BLANK_LZ, default 1, meaning leading-zero blanking is enabled.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port en, input, 1, meaning display enable; 0 turns all anodes off.
REQ-006 SHALL have port load, input, 1, meaning a one-cycle strobe that captures value and dp_in.
REQ-007 SHALL have port value, input, 16, meaning four hex nibbles, where nibble i drives digit i and digit 0 is the rightmost.
REQ-008 SHALL have port dp_in, input, 4, meaning active-high decimal point per digit.
REQ-009 SHALL have port ready, output, 1, meaning that no captured value is awaiting commit.
REQ-010 SHALL have port an, output, 4, meaning active-low one-hot digit anode select.
REQ-011 SHALL have port seg, output, 7, meaning active-low gfedcba segments.
REQ-012 SHALL have port dp, output, 1, meaning active-low decimal point.

Function
REQ-013 Prescaler SHALL count 0..DIV-1 and wrap; tick = (prescaler == DIV-1).
REQ-014 Digit index idx SHALL advance on tick, wrapping 3 -> 0; frame_end = tick AND idx == 3.
REQ-015 On load, value and dp_in SHALL be written to the shadow registers and pending SHALL be set.
REQ-016 On frame_end with pending set, active SHALL take shadow and pending SHALL clear; active never changes mid-frame.
REQ-017 When load and frame_end coincide, active SHALL take value/dp_in directly and pending SHALL end cleared.
REQ-018 When load occurs while pending is set, it SHALL overwrite shadow (last write wins) and pending SHALL stay set.
REQ-019 ready SHALL equal NOT pending, combinationally.
REQ-020 Nibble selection: nib = active[4*idx+3 : 4*idx].
REQ-021 Segment encoding SHALL be active-low hex: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-022 With BLANK_LZ=1, digit i>0 SHALL be blanked (seg=1111111) when active nibbles i..3 are all zero; digit 0 is never blanked.
REQ-023 A blanked digit SHALL still show its decimal point when its dp bit is set.
REQ-024 an, seg and dp SHALL be registered, reflecting idx and active from the previous cycle, with 1-cycle latency.
REQ-025 With en=0, the next-cycle outputs SHALL be an=1111, seg=1111111 and dp=1, while the prescaler, idx and the load path keep running.

Reset
REQ-026 On rst, the following SHALL hold: prescaler=0, idx=0, active=0, shadow=0, active dp=0, pending=0, an=1111, seg=1111111, dp=1; consequently ready=1.
REQ-027 rst SHALL override a simultaneous load; a pending value SHALL be discarded.

Structure
REQ-028 Segment-code constants (hex table, SEG_OFF=1111111) and the digit count of 4 SHALL reside in shared package seg_pkg.
REQ-029 Prescaler/tick generation SHALL be a sub-module named scan_tick with parameter DIV, ports clk, rst and tick.
REQ-030 The hex-to-segment decode SHALL be a function in seg_pkg, not a separate module.

Verification (DIV=4)
REQ-031 Release rst with en=1 -> 1 cycle later an=1110 and seg=1000000; an steps 1101, 1011, 0111 every 4 clocks, then wraps to 1110.
REQ-032 Pulse load with value=16'h00A5 mid-frame -> ready=0 until frame_end; the next frame shows 5, A, blank, blank (1111111); ready returns to 1.
REQ-033 Pulse load with 16'h1234 then 16'h5678 within one frame -> the next frame shows 8, 7, 6, 5 only.
REQ-034 Pulse load with 16'hF00F and dp_in=4'b0100 on the frame_end cycle -> the following frame shows F, 0, 0 with dp=0, F; ready stays 1.
REQ-035 Drive en=0 for 10 cycles, then en=1 -> outputs are off during en=0, and scanning resumes at the idx sequence unbroken.
REQ-036 Assert rst while pending, in the same cycle as a load -> ready=1, active=0, an=1111 on the next cycle.
